// File: rtl/psk_symbol_sequencer.sv
// psk_symbol_sequencer
// Accepts BPSK/QPSK symbols over valid/ready, maps each one to a starting
// carrier quadrant, then walks the per-quarter sample counter and quadrant
// so the phase accumulator and waveform LUT can produce the carrier.
// Symbols that arrive on the final sample of the previous symbol follow it
// with no idle cycle in between.

module psk_symbol_sequencer #(
  parameter int CNT_W       = 6,
  parameter int QUARTER_LEN = 64,
  parameter int CYC_PER_SYM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             run_en,
  input  logic             abort,
  input  logic             sym_valid,
  input  logic [1:0]       sym_data,
  output logic             sym_ready,
  output logic [CNT_W-1:0] sample_idx,
  output logic             clr_bit,
  output logic             en_bit,
  output logic             sign,
  output logic             phase,
  output logic             sym_done,
  output logic             busy,
  output logic             underrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(QUARTER_LEN - 1);
  localparam logic [5:0]       LAST_QTR = 6'(4 * CYC_PER_SYM - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [5:0]       qtr_q, qtr_d;
  logic [1:0]       quad_q, quad_d;
  logic             clr_q, clr_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;

  logic [CNT_W-1:0] idx_step;
  logic [5:0]       qtr_step;
  logic [1:0]       quad_step;
  logic [1:0]       start_quad;
  logic             last_sample;
  logic             step_is_last;
  logic             accept;

  // The final sample of a symbol is the last index of the last quarter.
  assign last_sample = (state_q == RUN) && (idx_q == LAST_IDX) && (qtr_q == LAST_QTR);

  // Ready in IDLE, or on the final sample when that sample is actually
  // advancing; abort and reset both block acceptance.
  assign sym_ready = rst && !abort && ((state_q == IDLE) || (last_sample && run_en));
  assign accept    = sym_valid && sym_ready;

  // Starting quadrant: BPSK uses bit 0 as a 0/180 degree choice, QPSK
  // treats the symbol as Gray code so adjacent quadrants differ in one bit.
  always_comb begin
    start_quad = 2'd0;
    if (mode) begin
      start_quad = {sym_data[1], sym_data[1] ^ sym_data[0]};
    end else begin
      start_quad = sym_data[0] ? 2'd2 : 2'd0;
    end
  end

  // One sample of progress: the index wraps at the end of a quarter and
  // carries into both the quarter count and the quadrant (mod 4).
  always_comb begin
    idx_step  = idx_q + CNT_W'(1);
    qtr_step  = qtr_q;
    quad_step = quad_q;
    if (idx_q == LAST_IDX) begin
      idx_step  = '0;
      qtr_step  = qtr_q + 6'd1;
      quad_step = quad_q + 2'd1;
    end
  end

  // sym_done is registered, so it is raised on the step that lands on the
  // final sample and is therefore visible throughout that sample.
  assign step_is_last = (idx_step == LAST_IDX) && (qtr_step == LAST_QTR);

  // Next-state and next-output logic; abort outranks accept, which outranks
  // the normal run/stall behaviour.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    qtr_d      = qtr_q;
    quad_d     = quad_q;
    clr_d      = clr_q;
    en_d       = en_q;
    done_d     = done_q;
    busy_d     = busy_q;
    underrun_d = underrun_q;

    if (abort) begin
      state_d    = IDLE;
      idx_d      = '0;
      qtr_d      = 6'd0;
      quad_d     = 2'd0;
      clr_d      = 1'b0;
      en_d       = 1'b0;
      done_d     = 1'b0;
      busy_d     = 1'b0;
      underrun_d = 1'b0;
    end else if (accept) begin
      state_d = RUN;
      idx_d   = '0;
      qtr_d   = 6'd0;
      quad_d  = start_quad;
      clr_d   = 1'b1;
      en_d    = 1'b1;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d  = '0;
          qtr_d  = 6'd0;
          quad_d = 2'd0;
          clr_d  = 1'b0;
          en_d   = 1'b0;
          done_d = 1'b0;
          busy_d = 1'b0;
        end
        RUN: begin
          if (!run_en) begin
            en_d   = 1'b0;
            done_d = 1'b0;
          end else if (last_sample) begin
            state_d    = IDLE;
            idx_d      = '0;
            qtr_d      = 6'd0;
            quad_d     = 2'd0;
            clr_d      = 1'b0;
            en_d       = 1'b0;
            done_d     = 1'b0;
            busy_d     = 1'b0;
            underrun_d = 1'b1;
          end else begin
            idx_d  = idx_step;
            qtr_d  = qtr_step;
            quad_d = quad_step;
            clr_d  = 1'b0;
            en_d   = 1'b1;
            done_d = step_is_last;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      qtr_q      <= 6'd0;
      quad_q     <= 2'd0;
      clr_q      <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      qtr_q      <= qtr_d;
      quad_q     <= quad_d;
      clr_q      <= clr_d;
      en_q       <= en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_idx = idx_q;
  assign clr_bit    = clr_q;
  assign en_bit     = en_q;
  assign sign       = quad_q[1];
  assign phase      = quad_q[0];
  assign sym_done   = done_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;

endmodule
